mem_fill_responder: RTL and testbench

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

---
 rtl/mem_fill_responder_pkg.sv | 35 +++
 rtl/mem_fill_responder_mem_array.sv | 44 ++++
 rtl/mem_fill_responder.sv | 136 +++++++++++++
 tb/tb_mem_fill_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_responder_pkg.sv
// Shared memory-system definitions used by the cache fill logic.
//   WORD_W / BLOCK_WORDS / BLOCK_MASK : word size, words per block, block-align mask
//   fill_state_t                      : fill sequencer state encoding
//   fill_beat_t                       : one returned beat (byte address + word)
package mem_fill_responder_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned BEAT_W      = 3;
    localparam int unsigned WAIT_W      = 4;

    localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } fill_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } fill_beat_t;

    // Byte address of beat k in a block; the beat index is OR-ed into the
    // cleared low nibble so it never carries into bit 4.
    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [ADDR_W-1:0] base,
        input logic [BEAT_W-1:0] beat
    );
        return (base & BLOCK_MASK) | ADDR_W'({beat, 1'b0});
    endfunction

endpackage

// File: rtl/mem_fill_responder_mem_array.sv
// Backing store: MEM_WORDS x WORD_W, one synchronous write port and one
// combinational read port with write-to-read bypass.
//   clk       : clock
//   wr_en     : write enable
//   wr_addr   : byte address of the write (word index = addr[IDX_W:1])
//   wr_data   : write data
//   rd_addr   : byte address of the read
//   rd_data_c : read data; shows wr_data when the same word is written this cycle
module mem_array
    import mem_fill_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
)
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data_c
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    logic [WORD_W-1:0] mem [MEM_WORDS];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              unused_addr_bits;

    // Byte bit and bits above the array size are don't-care (addresses alias).
    assign wr_idx           = wr_addr[IDX_W:1];
    assign rd_idx           = rd_addr[IDX_W:1];
    assign unused_addr_bits = ^{wr_addr, rd_addr};

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data_c = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

endmodule

// File: rtl/mem_fill_responder.sv
// Block-fill responder: accepts a fill request, waits LATENCY-1 cycles, then
// returns the 8 words of the aligned 16-byte block as gap-free beats.
//   clk, rst       : clock, asynchronous active-high reset
//   req_valid      : fill request (accepted only in IDLE)
//   req_addr       : byte address of the missing word
//   busy           : high while a fill is in WAIT or BURST
//   data_valid     : one cycle per returned word
//   data_out       : returned word (zero when data_valid is low)
//   data_addr      : byte address of data_out (zero when data_valid is low)
//   wr_en/wr_addr/wr_data : store-through write port, active in any state
module mem_fill_responder
    import mem_fill_responder_pkg::*;
#(
    parameter int unsigned LATENCY   = 4,    // 1..15
    parameter int unsigned MEM_WORDS = 1024  // power of two
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              busy,
    output logic              data_valid,
    output logic [WORD_W-1:0] data_out,
    output logic [ADDR_W-1:0] data_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data
);

    // Wait counter counts down to zero; LATENCY-1 WAIT cycles in total.
    localparam logic [WAIT_W-1:0] WAIT_LOAD = (LATENCY > 1) ? WAIT_W'(LATENCY - 2) : '0;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    fill_state_t       state,    state_n;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_n;
    logic [ADDR_W-1:0] base,     base_n;
    logic              busy_n;
    logic              launch_c;
    fill_beat_t        beat_q,   beat_n;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [WORD_W-1:0] rd_data_c;

    // The read for a beat and any write share the edge that launches the beat,
    // so a write on that edge is bypassed into the beat.
    mem_array #(
        .MEM_WORDS (MEM_WORDS)
    ) u_mem (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    // Next-state, counters and next beat payload.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        beat_cnt_n = beat_cnt;
        base_n     = base;
        launch_c   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    base_n     = req_addr & BLOCK_MASK;
                    beat_cnt_n = '0;
                    if (LATENCY == 1) begin
                        state_n  = ST_BURST;
                        launch_c = 1'b1;
                    end else begin
                        state_n    = ST_WAIT;
                        wait_cnt_n = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_n  = ST_BURST;
                    launch_c = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt - WAIT_W'(1);
                end
            end
            ST_BURST: begin
                if (beat_cnt == LAST_BEAT) begin
                    state_n    = ST_IDLE;
                    beat_cnt_n = '0;
                end else begin
                    beat_cnt_n = beat_cnt + BEAT_W'(1);
                    launch_c   = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        rd_addr_c = beat_addr(base_n, beat_cnt_n);
        busy_n    = (state_n != ST_IDLE);

        beat_n = '0;
        if (launch_c) begin
            beat_n.addr = rd_addr_c;
            beat_n.data = rd_data_c;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            beat_cnt   <= '0;
            base       <= '0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            beat_q     <= '0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            beat_cnt   <= beat_cnt_n;
            base       <= base_n;
            busy       <= busy_n;
            data_valid <= launch_c;
            beat_q     <= beat_n;
        end
    end

    assign data_out  = beat_q.data;
    assign data_addr = beat_q.addr;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Scoreboard bench for mem_fill_responder: instance 0 uses LATENCY=4,
// instance 1 uses LATENCY=1. Stimulus pushes expected beats (cycle, address,
// word); a negedge monitor pops and compares every beat the DUTs present.
`timescale 1ns/1ps
module tb_mem_fill_responder;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  req_valid;
    logic [15:0] req_addr   [2];
    logic [1:0]  busy;
    logic [1:0]  data_valid;
    logic [15:0] data_out   [2];
    logic [15:0] data_addr  [2];
    logic [1:0]  wr_en;
    logic [15:0] wr_addr    [2];
    logic [15:0] wr_data    [2];

    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];

    mem_fill_responder #(.LATENCY(4), .MEM_WORDS(1024)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
        .busy(busy[0]), .data_valid(data_valid[0]), .data_out(data_out[0]),
        .data_addr(data_addr[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0])
    );

    mem_fill_responder #(.LATENCY(1), .MEM_WORDS(1024)) dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
        .busy(busy[1]), .data_valid(data_valid[1]), .data_out(data_out[1]),
        .data_addr(data_addr[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1])
    );

    always #5 clk = ~clk;

    // Edge counter: after the N-th rising edge cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_beat(input int d, input int c, input logic [15:0] a, input logic [15:0] v);
        exp_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = v;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic v, input logic [15:0] a, input logic [15:0] w);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : q1.size();
        if (v) begin
            if (n == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut%0d unexpected_beat: got addr %0h data %0h, expected none (cycle %0d)",
                         d, a, w, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("dut%0d beat_cycle", d), 32'(cyc), 32'(e.cyc));
                chk($sformatf("dut%0d beat_addr", d), 32'(a), 32'(e.addr));
                chk($sformatf("dut%0d beat_data", d), 32'(w), 32'(e.data));
            end
        end else begin
            chk($sformatf("dut%0d idle_zero", d), {a, w}, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, data_valid[0], data_addr[0], data_out[0]);
        mon(1, data_valid[1], data_addr[1], data_out[1]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_pos(input int c);
        do step(); while (cyc < c);
    endtask

    task automatic at_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wr(input int d, input logic [15:0] a, input logic [15:0] v);
        wr_en[d]   = 1'b1;
        wr_addr[d] = a;
        wr_data[d] = v;
        step();
        wr_en[d]   = 1'b0;
    endtask

    initial begin
        int t;
        rst       = 2'b11;
        req_valid = 2'b00;
        wr_en     = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_addr[d] = '0;
            wr_addr[d]  = '0;
            wr_data[d]  = '0;
        end

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy[0]), 32'h0);
        chk("reset data_valid", 32'(data_valid[0]), 32'h0);
        chk("reset data_out", 32'(data_out[0]), 32'h0);
        chk("reset data_addr", 32'(data_addr[0]), 32'h0);
        step();
        rst = 2'b00;

        // Preload: words 0x18..0x1F = A000+i, words 0x20..0x27 = B000+i.
        for (int i = 0; i < 8; i++) begin
            wr(0, 16'h0030 + 16'(2 * i), 16'hA000 + 16'(i));
            wr(0, 16'h0040 + 16'(2 * i), 16'hB000 + 16'(i));
            wr(1, 16'h0030 + 16'(2 * i), 16'hA000 + 16'(i));
        end

        // Basic fill, LATENCY=4, unaligned request address.
        chk("pre_req busy", 32'(busy[0]), 32'h0);
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h0036;
        t = cyc + 1;
        for (int k = 0; k < 8; k++) push_beat(0, t + 3 + k, 16'h0030 + 16'(2 * k), 16'hA000 + 16'(k));
        step();
        req_valid[0] = 1'b0;
        at_neg(t);
        chk("busy_rise", 32'(busy[0]), 32'h1);
        at_neg(t + 10);
        chk("busy_last_beat", 32'(busy[0]), 32'h1);
        at_neg(t + 11);
        chk("busy_fall", 32'(busy[0]), 32'h0);
        step();

        // req_valid held high: one burst per acceptance, re-accept only in IDLE.
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h004F;
        t = cyc + 1;
        for (int k = 0; k < 8; k++) push_beat(0, t + 3 + k, 16'h0040 + 16'(2 * k), 16'hB000 + 16'(k));
        for (int k = 0; k < 8; k++) push_beat(0, t + 15 + k, 16'h0040 + 16'(2 * k), 16'hB000 + 16'(k));
        at_neg(t + 11);
        chk("held_req idle_gap busy", 32'(busy[0]), 32'h0);
        at_pos(t + 12);
        req_valid[0] = 1'b0;
        at_neg(t + 12);
        chk("held_req reaccept busy", 32'(busy[0]), 32'h1);
        at_pos(t + 24);

        // Write to a later beat of the active burst (during beat 2).
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h0040;
        t = cyc + 1;
        for (int k = 0; k < 8; k++)
            push_beat(0, t + 3 + k, 16'h0040 + 16'(2 * k), (k == 5) ? 16'h5555 : 16'hB000 + 16'(k));
        step();
        req_valid[0] = 1'b0;
        at_pos(t + 5);
        wr(0, 16'h004A, 16'h5555);
        at_pos(t + 12);
        wr(0, 16'h004A, 16'hB005);

        // Write landing on the edge that launches beat 5 (bypass), plus a write
        // to the already-returned beat 0 that must not change it.
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h0042;
        t = cyc + 1;
        for (int k = 0; k < 8; k++)
            push_beat(0, t + 3 + k, 16'h0040 + 16'(2 * k), (k == 5) ? 16'h5555 : 16'hB000 + 16'(k));
        step();
        req_valid[0] = 1'b0;
        at_pos(t + 6);
        wr(0, 16'h0040, 16'h1234);
        wr(0, 16'h004A, 16'h5555);
        at_pos(t + 12);

        // Both writes persist in memory.
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h004C;
        t = cyc + 1;
        for (int k = 0; k < 8; k++)
            push_beat(0, t + 3 + k, 16'h0040 + 16'(2 * k),
                      (k == 0) ? 16'h1234 : (k == 5) ? 16'h5555 : 16'hB000 + 16'(k));
        step();
        req_valid[0] = 1'b0;
        at_pos(t + 12);

        // Reset during beat 3 aborts the burst; memory survives.
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h0030;
        t = cyc + 1;
        for (int k = 0; k < 4; k++) push_beat(0, t + 3 + k, 16'h0030 + 16'(2 * k), 16'hA000 + 16'(k));
        step();
        req_valid[0] = 1'b0;
        at_neg(t + 6);
        #1;
        rst[0] = 1'b1;
        #1;
        chk("abort data_valid", 32'(data_valid[0]), 32'h0);
        chk("abort busy", 32'(busy[0]), 32'h0);
        chk("abort data_out", 32'(data_out[0]), 32'h0);
        @(negedge clk);
        #1;
        rst[0] = 1'b0;
        at_pos(t + 22);
        chk("post_abort busy", 32'(busy[0]), 32'h0);
        chk("post_abort queue", 32'(q0.size()), 32'h0);
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h003A;
        t = cyc + 1;
        for (int k = 0; k < 8; k++) push_beat(0, t + 3 + k, 16'h0030 + 16'(2 * k), 16'hA000 + 16'(k));
        step();
        req_valid[0] = 1'b0;
        at_pos(t + 12);

        // LATENCY=1: first beat right after acceptance, back-to-back re-accept.
        req_valid[1] = 1'b1;
        req_addr[1]  = 16'h0038;
        t = cyc + 1;
        for (int k = 0; k < 8; k++) push_beat(1, t + k, 16'h0030 + 16'(2 * k), 16'hA000 + 16'(k));
        for (int k = 0; k < 8; k++) push_beat(1, t + 9 + k, 16'h0030 + 16'(2 * k), 16'hA000 + 16'(k));
        at_neg(t);
        chk("lat1 busy_rise", 32'(busy[1]), 32'h1);
        at_neg(t + 8);
        chk("lat1 idle_cycle busy", 32'(busy[1]), 32'h0);
        at_pos(t + 9);
        req_valid[1] = 1'b0;
        at_neg(t + 9);
        chk("lat1 reaccept busy", 32'(busy[1]), 32'h1);
        at_pos(t + 19);

        chk("dut0 queue_drained", 32'(q0.size()), 32'h0);
        chk("dut1 queue_drained", 32'(q1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
